// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier arbiter: FSM state encoding and default operand widths.
package mult_pkg;

  localparam int unsigned DEF_INPUT1_WIDTH = 4;
  localparam int unsigned DEF_INPUT2_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: one-hot grant to the first requester after ptr, wrapping around.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0] idx;
  logic            found;

  // Scan ptr+1 .. ptr+NUM_REQ so the last granted index has lowest priority.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((32'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one external multiplier among NUM_REQ requesters, one op in flight.
// Optional MULT_ARBITER_STATS_EN adds a 16-bit completed-operation counter output op_count.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int unsigned INPUT1_WIDTH = DEF_INPUT1_WIDTH,
  parameter int unsigned INPUT2_WIDTH = DEF_INPUT2_WIDTH,
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned MULT_LATENCY = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ*INPUT1_WIDTH-1:0]      req_a,
  input  logic [NUM_REQ*INPUT2_WIDTH-1:0]      req_b,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [INPUT1_WIDTH-1:0]              mult_a,
  output logic [INPUT2_WIDTH-1:0]              mult_b,
  input  logic [INPUT1_WIDTH+INPUT2_WIDTH-1:0] mult_p,
  output logic                                 resp_valid,
  output logic [$clog2(NUM_REQ)-1:0]           resp_id,
  output logic [INPUT1_WIDTH+INPUT2_WIDTH-1:0] resp_p,
  input  logic                                 resp_ready
`ifdef MULT_ARBITER_STATS_EN
  ,
  output logic [15:0]                          op_count
`endif
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned P_W   = INPUT1_WIDTH + INPUT2_WIDTH;
  localparam int unsigned CNT_W = 4;

  state_t                  state, state_next;
  logic [ID_W-1:0]         ptr, ptr_next;
  logic [ID_W-1:0]         id_q, id_next;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic [INPUT1_WIDTH-1:0] mult_a_next;
  logic [INPUT2_WIDTH-1:0] mult_b_next;
  logic                    resp_valid_next;
  logic [ID_W-1:0]         resp_id_next;
  logic [P_W-1:0]          resp_p_next;
`ifdef MULT_ARBITER_STATS_EN
  logic [15:0]             op_count_next;
`endif

  logic [NUM_REQ-1:0]      grant;
  logic [ID_W-1:0]         grant_idx;
  logic [INPUT1_WIDTH-1:0] sel_a;
  logic [INPUT2_WIDTH-1:0] sel_b;
  logic                    accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  // Grant is only offered while idle and out of reset.
  assign req_ready = (state == IDLE && rst_n) ? grant : '0;
  assign accept    = |(req_valid & req_ready);

  // Encode the one-hot grant and mux out the winner's operands.
  always_comb begin
    grant_idx = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = ID_W'(i);
        sel_a     = req_a[i*INPUT1_WIDTH +: INPUT1_WIDTH];
        sel_b     = req_b[i*INPUT2_WIDTH +: INPUT2_WIDTH];
      end
    end
  end

  always_comb begin
    state_next      = state;
    ptr_next        = ptr;
    id_next         = id_q;
    cnt_next        = cnt;
    mult_a_next     = mult_a;
    mult_b_next     = mult_b;
    resp_valid_next = resp_valid;
    resp_id_next    = resp_id;
    resp_p_next     = resp_p;
`ifdef MULT_ARBITER_STATS_EN
    op_count_next   = op_count;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          mult_a_next = sel_a;
          mult_b_next = sel_b;
          id_next     = grant_idx;
          ptr_next    = grant_idx;
          state_next  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next   = CNT_W'(MULT_LATENCY - 1);
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt == '0) begin
          resp_p_next     = mult_p;
          resp_id_next    = id_q;
          resp_valid_next = 1'b1;
          state_next      = RESP;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_next = 1'b0;
          state_next      = IDLE;
`ifdef MULT_ARBITER_STATS_EN
          op_count_next   = op_count + 16'd1;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= ID_W'(NUM_REQ - 1);
      id_q       <= '0;
      cnt        <= '0;
      mult_a     <= '0;
      mult_b     <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_p     <= '0;
`ifdef MULT_ARBITER_STATS_EN
      op_count   <= '0;
`endif
    end else begin
      state      <= state_next;
      ptr        <= ptr_next;
      id_q       <= id_next;
      cnt        <= cnt_next;
      mult_a     <= mult_a_next;
      mult_b     <= mult_b_next;
      resp_valid <= resp_valid_next;
      resp_id    <= resp_id_next;
      resp_p     <= resp_p_next;
`ifdef MULT_ARBITER_STATS_EN
      op_count   <= op_count_next;
`endif
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a two-stage pipelined multiplier model (MULT_LATENCY=2).
module tb_mult_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [19:0] req_b;
  logic [3:0]  req_ready;
  logic [3:0]  mult_a;
  logic [4:0]  mult_b;
  logic [8:0]  mult_p;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [8:0]  resp_p;
  logic        resp_ready;
`ifdef MULT_ARBITER_STATS_EN
  logic [15:0] op_count;
`endif

  int checks   = 0;
  int failures = 0;

  logic [8:0] pipe1, pipe2;

  mult_arbiter #(
    .INPUT1_WIDTH (4),
    .INPUT2_WIDTH (5),
    .NUM_REQ      (4),
    .MULT_LATENCY (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_p     (mult_p),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_p     (resp_p),
    .resp_ready (resp_ready)
`ifdef MULT_ARBITER_STATS_EN
    ,
    .op_count   (op_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Product valid two cycles after the operands are driven.
  always_ff @(posedge clk) begin
    pipe1 <= 9'(mult_a) * 9'(mult_b);
    pipe2 <= pipe1;
  end
  assign mult_p = pipe2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic issue(input int idx, input logic [3:0] a, input logic [4:0] b);
    req_valid          = '0;
    req_valid[idx]     = 1'b1;
    req_a[idx*4 +: 4]  = a;
    req_b[idx*5 +: 5]  = b;
    tick();
    req_valid = '0;
  endtask

  // Ticks until resp_valid; total reports cycles since acceptance edge, 99 on timeout.
  task automatic wait_resp(output int total);
    int cyc;
    cyc = 1;
    while (resp_valid !== 1'b1 && cyc < 50) begin
      tick();
      cyc++;
    end
    total = (resp_valid === 1'b1) ? cyc : 99;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (req_ready !== 4'b0 || resp_valid !== 1'b0 || resp_id !== 2'd0 ||
        resp_p !== 9'd0 || mult_a !== 4'd0 || mult_b !== 5'd0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b rv=%b id=%0d p=%0d a=%0d b=%0d, want all 0",
               req_ready, resp_valid, resp_id, resp_p, mult_a, mult_b);
    end
  endtask

  task automatic test_single();
    int lat;
    do_reset();
    req_valid = 4'b0001;
    req_a[3:0] = 4'hF;
    req_b[4:0] = 5'h1F;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL single_grant: req_ready=%b want 0001", req_ready);
    end
    tick();
    req_valid = '0;
    checks++;
    if (req_ready !== 4'b0 || mult_a !== 4'hF || mult_b !== 5'h1F) begin
      failures++;
      $display("FAIL single_issue: ready=%b a=%h b=%h want 0000 f 1f", req_ready, mult_a, mult_b);
    end
    wait_resp(lat);
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL single_latency: got %0d want 4", lat);
    end
    checks++;
    if (resp_id !== 2'd0 || resp_p !== 9'd465) begin
      failures++;
      $display("FAIL single_result: id=%0d p=%0d want 0 465", resp_id, resp_p);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_handshake: resp_valid=%b want 0", resp_valid);
    end
  endtask

  task automatic test_round_robin();
    int lat;
    logic [1:0] exp_id;
    logic [8:0] exp_p [4];
    logic [3:0] exp_ready;
    exp_p[0] = 9'd15;
    exp_p[1] = 9'd60;
    exp_p[2] = 9'd119;
    exp_p[3] = 9'd279;
    rst_n      = 1'b0;
    req_valid  = 4'b1111;
    req_a      = {4'd9, 4'd7, 4'd6, 4'd5};
    req_b      = {5'd31, 5'd17, 5'd10, 5'd3};
    resp_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      exp_id    = 2'(k % 4);
      exp_ready = 4'(1 << (k % 4));
      checks++;
      if (req_ready !== exp_ready) begin
        failures++;
        $display("FAIL rr_grant_%0d: req_ready=%b want %b", k, req_ready, exp_ready);
      end
      tick();
      wait_resp(lat);
      checks++;
      if (resp_id !== exp_id || resp_p !== exp_p[exp_id] || lat !== 4) begin
        failures++;
        $display("FAIL rr_result_%0d: id=%0d p=%0d lat=%0d want %0d %0d 4",
                 k, resp_id, resp_p, lat, exp_id, exp_p[exp_id]);
      end
      tick();
    end
    req_valid  = '0;
    resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    do_reset();
    issue(2, 4'hA, 5'h0C);
    wait_resp(lat);
    req_valid = 4'b1111;
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL bp_latency: got %0d want 4", lat);
    end
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_p !== 9'd120 || req_ready !== 4'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d: rv=%b id=%0d p=%0d ready=%b want 1 2 120 0000",
                 k, resp_valid, resp_id, resp_p, req_ready);
      end
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL bp_release: rv=%b ready=%b want 0 1000", resp_valid, req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_reset_in_wait();
    int lat;
    int seen;
    do_reset();
    issue(3, 4'd7, 5'd3);
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (req_ready !== 4'b0 || resp_valid !== 1'b0 || resp_id !== 2'd0 ||
        resp_p !== 9'd0 || mult_a !== 4'd0 || mult_b !== 5'd0) begin
      failures++;
      $display("FAIL wait_reset_outputs: ready=%b rv=%b id=%0d p=%0d a=%0d b=%0d, want all 0",
               req_ready, resp_valid, resp_id, resp_p, mult_a, mult_b);
    end
    rst_n = 1'b1;
    seen  = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (resp_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL wait_reset_no_resp: resp_valid seen %0d cycles want 0", seen);
    end
    req_valid = 4'b1001;
    req_a[3:0]   = 4'd2;
    req_b[4:0]   = 5'd9;
    req_a[15:12] = 4'd1;
    req_b[19:15] = 5'd1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL wait_reset_priority: req_ready=%b want 0001", req_ready);
    end
    tick();
    req_valid = '0;
    wait_resp(lat);
    checks++;
    if (resp_id !== 2'd0 || resp_p !== 9'd18 || lat !== 4) begin
      failures++;
      $display("FAIL wait_reset_fresh: id=%0d p=%0d lat=%0d want 0 18 4", resp_id, resp_p, lat);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_boundary();
    int lat;
    do_reset();
    resp_ready = 1'b1;
    issue(1, 4'h0, 5'h1F);
    wait_resp(lat);
    checks++;
    if (resp_id !== 2'd1 || resp_p !== 9'd0 || lat !== 4) begin
      failures++;
      $display("FAIL boundary_zero: id=%0d p=%0d lat=%0d want 1 0 4", resp_id, resp_p, lat);
    end
    tick();
    issue(1, 4'h8, 5'h10);
    wait_resp(lat);
    checks++;
    if (resp_id !== 2'd1 || resp_p !== 9'd128 || lat !== 4) begin
      failures++;
      $display("FAIL boundary_msb: id=%0d p=%0d lat=%0d want 1 128 4", resp_id, resp_p, lat);
    end
    tick();
    resp_ready = 1'b0;
  endtask

`ifdef MULT_ARBITER_STATS_EN
  task automatic test_stats();
    int lat;
    do_reset();
    resp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      issue(k, 4'd3, 5'd3);
      wait_resp(lat);
      tick();
    end
    checks++;
    if (op_count !== 16'd3) begin
      failures++;
      $display("FAIL stats_count: op_count=%0d want 3", op_count);
    end
    dut.op_count = 16'hFFFF;
    issue(0, 4'd1, 5'd1);
    wait_resp(lat);
    tick();
    checks++;
    if (op_count !== 16'd0) begin
      failures++;
      $display("FAIL stats_wrap: op_count=%h want 0000", op_count);
    end
    resp_ready = 1'b0;
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_in_wait();
    test_boundary();
`ifdef MULT_ARBITER_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter INPUT1_WIDTH, default 4, multiplicand width.
REQ-002 SHALL have parameter INPUT2_WIDTH, default 5, multiplier width.
REQ-003 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-004 SHALL have parameter MULT_LATENCY, default 2, cycles from operand drive to a valid mult_p (1..15).
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port req_valid  in  NUM_REQ  per-requester operation request.
REQ-008 SHALL have port req_a  in  NUM_REQ*INPUT1_WIDTH  packed multiplicands, requester i at slice i.
REQ-009 SHALL have port req_b  in  NUM_REQ*INPUT2_WIDTH  packed multipliers.
REQ-010 SHALL have port req_ready  out  NUM_REQ  one-hot grant; a request is accepted when req_valid[i] and req_ready[i] are both high.
REQ-011 SHALL have port mult_a  out  INPUT1_WIDTH  operand to shared array multiplier.
REQ-012 SHALL have port mult_b  out  INPUT2_WIDTH  operand to shared array multiplier.
REQ-013 SHALL have port mult_p  in  INPUT1_WIDTH+INPUT2_WIDTH  product from the multiplier.
REQ-014 SHALL have port resp_valid  out  1  result available.
REQ-015 SHALL have port resp_id  out  $clog2(NUM_REQ)  index of the requester owning the result.
REQ-016 SHALL have port resp_p  out  INPUT1_WIDTH+INPUT2_WIDTH  captured product.
REQ-017 SHALL have port resp_ready  in  1  consumer accepts the result.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: if any req_valid is high, SHALL select a requester by round-robin starting at the index after the last granted one (index 0 after reset), and SHALL assert req_ready only for that index in the same cycle (combinational from req_valid and the pointer).
REQ-020 On acceptance, SHALL register the operands and the index, update the pointer to the granted index, and go to ISSUE.
REQ-021 ISSUE: SHALL drive mult_a/mult_b from the registered operands, load the latency counter with MULT_LATENCY-1, and go to WAIT; mult_a/mult_b SHALL hold stable from ISSUE until the exit from WAIT.
REQ-022 WAIT: SHALL decrement the counter each cycle; when it is 0, SHALL capture mult_p into resp_p and go to RESP. Capture occurs exactly MULT_LATENCY cycles after the ISSUE cycle.
REQ-023 RESP: resp_valid SHALL be high; resp_id/resp_p SHALL stay stable until resp_ready is high; on handshake SHALL go to IDLE.
REQ-024 req_ready SHALL be all zeros in ISSUE, WAIT and RESP; at most one operation is in flight.
REQ-025 Requests deasserted before acceptance SHALL be dropped silently; a requester held valid SHALL be granted within NUM_REQ operations.
REQ-026 Best case, request accepted in cycle N gives resp_valid in cycle N+MULT_LATENCY+2.

Reset
REQ-027 With rst_n low at a clock edge, SHALL go to IDLE, set the round-robin pointer to NUM_REQ-1 (so index 0 has top priority), clear the counter, and drive req_ready=0, resp_valid=0, resp_id=0, resp_p=0, mult_a=0, mult_b=0.
REQ-028 Reset during WAIT or RESP SHALL discard the in-flight operation with no response.

Configuration
REQ-029 With MULT_ARBITER_STATS_EN defined, SHALL add output op_count (16 bits), incremented on each resp handshake, wrapping at 0xFFFF->0 and reset to 0; without the macro the port and counter SHALL not exist.

Structure
REQ-030 Shared package mult_pkg SHALL hold the FSM state enum and the default width constants (4, 5).
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector and pointer; output: one-hot grant).

Verification
REQ-032 Single request: req 0, a=4'hF, b=5'h1F, MULT_LATENCY=2 -> resp_id=0, resp_p=465, resp_valid 4 cycles after acceptance.
REQ-033 All four requesters held valid from reset -> grant order 0,1,2,3,0; each resp_p is correct for its operands.
REQ-034 Backpressure: resp_ready held low for 5 cycles in RESP -> resp_p/resp_id stable, req_ready stays 0, no new grant.
REQ-035 Reset asserted during WAIT -> next cycle all outputs 0, no response; a fresh request afterwards is granted to index 0 first when contending with index 3.
REQ-036 Boundary operands: a=0, b=5'h1F -> resp_p=0; a=4'h8, b=5'h10 -> resp_p=128.
REQ-037 With MULT_ARBITER_STATS_EN: 3 completed operations -> op_count=3; preloading to 16'hFFFF and completing one more -> op_count=0.
